systolic_feed_ctrl: RTL



---
 rtl/systolic_feed_ctrl_if.sv | 47 ++++
 rtl/systolic_feed_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl_if.sv
// Host-side and array-side signals of the systolic feed controller; master = host/array side, slave = controller.
// The abort input exists only when SYSTOLIC_ABORT_EN is defined.
interface systolic_feed_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic              wr_sel;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              arr_reset;
    logic [DATA_W-1:0] arr_a_0;
    logic [DATA_W-1:0] arr_a_1;
    logic [DATA_W-1:0] arr_a_2;
    logic [DATA_W-1:0] arr_b_0;
    logic [DATA_W-1:0] arr_b_1;
    logic [DATA_W-1:0] arr_b_2;
    logic [DATA_W-1:0] arr_out;
`ifdef SYSTOLIC_ABORT_EN
    logic              abort;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, arr_out, abort,
        input  busy, done, result, arr_reset,
               arr_a_0, arr_a_1, arr_a_2, arr_b_0, arr_b_1, arr_b_2
    );
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, arr_out, abort,
        output busy, done, result, arr_reset,
               arr_a_0, arr_a_1, arr_a_2, arr_b_0, arr_b_1, arr_b_2
    );
`else
    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, arr_out,
        input  busy, done, result, arr_reset,
               arr_a_0, arr_a_1, arr_a_2, arr_b_0, arr_b_1, arr_b_2
    );
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, arr_out,
        output busy, done, result, arr_reset,
               arr_a_0, arr_a_1, arr_a_2, arr_b_0, arr_b_1, arr_b_2
    );
`endif
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for a 3x3 systolic array: buffers A/B, clears the array, feeds skewed operands, drains, captures result.
// Latency: start at edge k -> done in cycle k+12, busy k+1..k+12. No backpressure; start/writes ignored while busy.
// SYSTOLIC_ABORT_EN adds an abort input that returns CLEAR/FEED/DRAIN to IDLE with a one-cycle arr_reset pulse.
module systolic_feed_ctrl #(
    parameter int DATA_W    = 8,
    parameter int N         = 3,
    parameter int DRAIN_CYC = 3
) (
    input logic                 clk,
    input logic                 reset,
    systolic_feed_ctrl_if.slave bus
);
    localparam int ELEMS    = N * N;
    localparam int FEED_CYC = 3 * N - 2;
    localparam int IDX_W    = $clog2(ELEMS);
    localparam int CNT_MAX  = (FEED_CYC > DRAIN_CYC) ? FEED_CYC : DRAIN_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [3:0]       ELEMS_A    = 4'(ELEMS);
    localparam logic [CNT_W-1:0] LAST_FEED  = CNT_W'(FEED_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAP
    } state_t;

    state_t                        state;
    state_t                        nxt_state;
    logic [CNT_W-1:0]              cnt;
    logic [CNT_W-1:0]              nxt_cnt;
    logic                          abort_req;
    logic                          abort_hit;

    logic [ELEMS-1:0][DATA_W-1:0]  a_buf;
    logic [ELEMS-1:0][DATA_W-1:0]  b_buf;

    logic [N-1:0][DATA_W-1:0]      nxt_a;
    logic [N-1:0][DATA_W-1:0]      nxt_b;
    logic [N-1:0][DATA_W-1:0]      a_q;
    logic [N-1:0][DATA_W-1:0]      b_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          arr_reset_q;
    logic [DATA_W-1:0]             result_q;

`ifdef SYSTOLIC_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        abort_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    nxt_state = S_CLEAR;
                    nxt_cnt   = '0;
                end
            end
            S_CLEAR: begin
                nxt_state = S_FEED;
                nxt_cnt   = '0;
            end
            S_FEED: begin
                if (cnt == LAST_FEED) begin
                    nxt_state = S_DRAIN;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    nxt_state = S_CAP;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_CAP: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        endcase
        // Abort wins over the normal advance; CAP is allowed to finish.
        if (abort_req && (state == S_CLEAR || state == S_FEED || state == S_DRAIN)) begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
            abort_hit = 1'b1;
        end
    end

    // Operand buffers only accept writes while idle, so a running job sees a stable matrix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (state == S_IDLE && bus.wr_en && bus.wr_addr < ELEMS_A) begin
            if (bus.wr_sel) begin
                b_buf[IDX_W'(bus.wr_addr)] <= bus.wr_data;
            end else begin
                a_buf[IDX_W'(bus.wr_addr)] <= bus.wr_data;
            end
        end
    end

    // Operands are computed for the upcoming cycle so the registered outputs line up with FEED step t.
    always_comb begin
        nxt_a = '0;
        nxt_b = '0;
        if (nxt_state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                if (int'(nxt_cnt) >= i && int'(nxt_cnt) - i < N) begin
                    nxt_a[i] = a_buf[IDX_W'(i * N + int'(nxt_cnt) - i)];
                    nxt_b[i] = b_buf[IDX_W'((int'(nxt_cnt) - i) * N + i)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arr_reset_q <= 1'b1;
            result_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            busy_q      <= (nxt_state != S_IDLE);
            done_q      <= (nxt_state == S_CAP);
            arr_reset_q <= (nxt_state == S_CLEAR) || abort_hit;
            a_q         <= nxt_a;
            b_q         <= nxt_b;
            if (state == S_CAP) begin
                result_q <= bus.arr_out;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.arr_reset = arr_reset_q;
    assign bus.result    = result_q;
    assign bus.arr_a_0   = a_q[0];
    assign bus.arr_a_1   = a_q[1];
    assign bus.arr_a_2   = a_q[2];
    assign bus.arr_b_0   = b_q[0];
    assign bus.arr_b_1   = b_q[1];
    assign bus.arr_b_2   = b_q[2];

endmodule
